mult_arbiter: RTL and testbench
===============================

MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter DATA_W, default 32, operand width in bits.
REQ-003 SHALL have port aclk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port aresetn  input  1  asynchronous active-low reset.
REQ-005 SHALL have port req_valid  input  N_REQ  per-requester operation request.
REQ-006 SHALL have port req_ready  output  N_REQ  per-requester accept (one-hot or zero).
REQ-007 SHALL have port req_a  input  N_REQ*DATA_W  operand A, requester i at bits [i*DATA_W +: DATA_W].
REQ-008 SHALL have port req_b  input  N_REQ*DATA_W  operand B, same packing as req_a.
REQ-009 SHALL have port rsp_valid  output  1  result available.
REQ-010 SHALL have port rsp_ready  input  1  result consumer accept.
REQ-011 SHALL have port rsp_id  output  $clog2(N_REQ)  index of the requester that owns the result.
REQ-012 SHALL have port rsp_r  output  2*DATA_W  unsigned product A*B.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM IDLE -> CALC -> RESP -> IDLE; one operation in flight at a time.
REQ-015 In IDLE, req_ready SHALL be asserted combinationally only for the arbitration winner among asserted req_valid bits; in other states req_ready SHALL be all zeros.
REQ-016 A request handshake (req_valid[i] & req_ready[i]) SHALL latch req_a/req_b slice i and index i, and move to CALC on that edge.
REQ-017 CALC SHALL last exactly DATA_W cycles (one shift-add step per cycle), then go to RESP.
REQ-018 rsp_valid SHALL rise DATA_W+1 rising edges after the request handshake edge; rsp_r and rsp_id SHALL be stable while rsp_valid is high.
REQ-019 RESP SHALL hold until rsp_valid & rsp_ready, then return to IDLE; a new grant SHALL be possible in the cycle after return (no same-cycle back-to-back).
REQ-020 Round-robin arbitration (default): the search SHALL start at (last_grant+1) mod N_REQ; last_grant SHALL update only on a request handshake.
REQ-021 Requests with req_valid low SHALL never be granted; all req_valid low in IDLE SHALL keep FSM in IDLE with req_ready all zeros.
REQ-022 Operands of 0 or all-ones SHALL yield exact products (0; (2^DATA_W-1)^2) with no truncation.
REQ-023 Requester inputs changing during CALC/RESP SHALL NOT affect the in-flight result.

Reset
REQ-024 aresetn low SHALL asynchronously force state IDLE, rsp_valid 0, rsp_r 0, rsp_id 0, busy 0, req_ready 0, last_grant N_REQ-1 (so requester 0 wins first).
REQ-025 Reset asserted mid-CALC or mid-RESP SHALL abandon the operation; no response SHALL be issued for it after release.

Configuration
REQ-026 With MULT_ARBITER_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority (lowest index wins) and last_grant logic SHALL be omitted.
REQ-027 Without MULT_ARBITER_FIXED_PRIO_EN, arbitration SHALL be round-robin per REQ-020.

Structure
REQ-028 A shared package mult_arbiter_pkg SHALL hold the FSM state encoding (IDLE=0, CALC=1, RESP=2) and default N_REQ/DATA_W constants.
REQ-029 The shift-add datapath SHALL be a sub-module mult_seq (start, a, b -> done, p), instantiated once; mult_arbiter owns arbitration, FSM and response registers.

Verification
REQ-030 Single req0 a=3 b=5 -> req_ready[0] same cycle, rsp_valid after 33 edges, rsp_r=15, rsp_id=0.
REQ-031 All four req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0; with MULT_ARBITER_FIXED_PRIO_EN -> 0,0,0,0.
REQ-032 a=b=0xFFFFFFFF -> rsp_r=0xFFFFFFFE00000001; a=0 b=0x1234 -> rsp_r=0.
REQ-033 rsp_ready low 10 cycles in RESP -> rsp_valid, rsp_r, rsp_id stable; req_ready all 0; busy 1.
REQ-034 aresetn pulsed low at CALC cycle 10 -> outputs at reset values immediately; no rsp_valid afterward; next grant goes to req0.
REQ-035 req_a[1] changed during CALC of a=7 b=9 from req1 -> rsp_r=63.

Source files
------------

// File: rtl/mult_arbiter_pkg.sv
// Shared constants and FSM encoding for the multiplier arbiter.
//   N_REQ_DEF  : default number of requesters
//   DATA_W_DEF : default operand width
//   state_e    : arbiter FSM states (IDLE=0, CALC=1, RESP=2)
package mult_arbiter_pkg;

  localparam int unsigned N_REQ_DEF  = 4;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/mult_arbiter_mult_seq.sv
// Sequential shift-add unsigned multiplier, one partial product per cycle.
//   aclk, aresetn : clock, async active-low reset
//   start         : load a/b and begin a new product (abandons any current one)
//   a, b          : operands, sampled only on start
//   done          : one-cycle pulse the cycle after the final step
//   p             : product, valid while done is high and held until next start
module mult_seq
  import mult_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                start,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  output logic                done,
  output logic [2*DATA_W-1:0] p
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  logic [2*DATA_W-1:0] mcand_q;
  logic [DATA_W-1:0]   mplier_q;
  logic [CNT_W-1:0]    cnt_q;

  // Accumulate the shifted multiplicand for each set multiplier bit, LSB first.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      p        <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        p        <= '0;
        mcand_q  <= {{DATA_W{1'b0}}, a};
        mplier_q <= b;
        cnt_q    <= CNT_W'(DATA_W);
      end else if (cnt_q != '0) begin
        if (mplier_q[0]) p <= p + mcand_q;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q - CNT_W'(1);
        done     <= (cnt_q == CNT_W'(1));
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// N-way arbiter in front of a single shared sequential multiplier.
// Build option: define MULT_ARBITER_FIXED_PRIO_EN for fixed priority
// (lowest index wins); default is round-robin.
//   aclk, aresetn : clock, async active-low reset
//   req_valid     : per-requester request
//   req_ready     : per-requester accept, combinational, one-hot or zero
//   req_a, req_b  : packed operands, requester i at [i*DATA_W +: DATA_W]
//   rsp_valid     : result available, held until rsp_ready
//   rsp_ready     : result consumer accept
//   rsp_id        : owner of the result
//   rsp_r         : unsigned product
//   busy          : FSM not in IDLE
module mult_arbiter
  import mult_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ  = N_REQ_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*DATA_W-1:0]   req_a,
  input  logic [N_REQ*DATA_W-1:0]   req_b,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [$clog2(N_REQ)-1:0]  rsp_id,
  output logic [2*DATA_W-1:0]       rsp_r,
  output logic                      busy
);

  localparam int unsigned ID_W  = $clog2(N_REQ);
  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    calc_cnt_q;
  logic [ID_W-1:0]     id_q;
  logic [ID_W-1:0]     gnt_idx;
  logic                gnt_found;
  logic                hs;
  logic                mul_done;
  logic [2*DATA_W-1:0] mul_p;

`ifdef MULT_ARBITER_FIXED_PRIO_EN
  // Fixed priority: descending scan so the lowest asserted index wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
      if (req_valid[k]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(k);
      end
    end
  end
`else
  logic [ID_W-1:0] last_grant_q;
  int              idx;

  // Round-robin: descending scan so the first valid after last_grant wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
      idx = (int'(last_grant_q) + 1 + k) % int'(N_REQ);
      if (req_valid[ID_W'(idx)]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)  last_grant_q <= ID_W'(N_REQ - 1);
    else if (hs)   last_grant_q <= gnt_idx;
  end
`endif

  // Grant is only offered in IDLE and never while reset is asserted.
  assign req_ready = (aresetn && state_q == IDLE && gnt_found)
                     ? (N_REQ'(1) << gnt_idx) : '0;
  assign hs        = |(req_valid & req_ready);

  // Operands are captured inside mult_seq on start, isolating the in-flight op.
  mult_seq #(.DATA_W(DATA_W)) u_mult_seq (
    .aclk    (aclk),
    .aresetn (aresetn),
    .start   (hs),
    .a       (req_a[int'(gnt_idx)*DATA_W +: DATA_W]),
    .b       (req_b[int'(gnt_idx)*DATA_W +: DATA_W]),
    .done    (mul_done),
    .p       (mul_p)
  );

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hs) state_d = CALC;
      CALC:    if (calc_cnt_q == CNT_W'(DATA_W - 1)) state_d = RESP;
      RESP:    if (rsp_valid && rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, CALC cycle counter and response registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      calc_cnt_q <= '0;
      id_q       <= '0;
      rsp_valid  <= 1'b0;
      rsp_r      <= '0;
      rsp_id     <= '0;
      busy       <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != IDLE);
      if (hs) begin
        id_q       <= gnt_idx;
        calc_cnt_q <= '0;
      end else if (state_q == CALC) begin
        calc_cnt_q <= calc_cnt_q + CNT_W'(1);
      end
      // The multiplier finishes in the first RESP cycle; publish on the next edge.
      if (state_q == RESP && mul_done) begin
        rsp_valid <= 1'b1;
        rsp_r     <= mul_p;
        rsp_id    <= id_q;
      end else if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter (N_REQ=4, DATA_W=32).
module tb_mult_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int LAT = W + 2; // negedge of handshake -> first negedge with rsp_valid

  logic           aclk = 1'b0;
  logic           aresetn = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b1;
  logic [1:0]     rsp_id;
  logic [2*W-1:0] rsp_r;
  logic           busy;

  mult_arbiter #(.N_REQ(N), .DATA_W(W)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_r(rsp_r), .busy(busy)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    int          id;
    logic [63:0] r;
  } exp_t;

  exp_t        sb[$];
  int          grants[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          hs_cyc = 0;
  int          hs_count = 0;
  int          rise_cnt = 0;
  int          model_last = N - 1;
  logic        prev_rv = 1'b0;
  logic [63:0] last_rsp_r = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int pick(input logic [N-1:0] v, input int last);
`ifdef MULT_ARBITER_FIXED_PRIO_EN
    for (int k = 0; k < N; k++) if (v[k]) return k;
`else
    for (int k = 0; k < N; k++) if (v[(last + 1 + k) % N]) return (last + 1 + k) % N;
`endif
    return -1;
  endfunction

  always @(posedge aclk) cyc <= cyc + 1;

  // Monitor: grants, scoreboard pushes, response latency and result pops.
  always @(negedge aclk) begin
    if (!aresetn) begin
      prev_rv = 1'b0;
    end else begin
      if (!busy && |req_valid) begin
        int ei;
        int ai;
        logic [N-1:0] oh;
        exp_t e;
        ei = pick(req_valid, model_last);
        oh = N'(1) << ei;
        check("grant", 64'(req_ready), 64'(oh));
        ai = -1;
        for (int k = 0; k < N; k++) if (req_ready[k]) ai = k;
        grants.push_back(ai);
        e.id = ei;
        e.r  = 64'(req_a[ei*W +: W]) * 64'(req_b[ei*W +: W]);
        sb.push_back(e);
        model_last = ei;
        hs_cyc = cyc;
        hs_count++;
      end
      if (rsp_valid && !prev_rv) begin
        rise_cnt++;
        check("latency", 64'(cyc - hs_cyc), 64'(LAT));
      end
      prev_rv = rsp_valid;
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_rsp", 64'(1), 64'(0));
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("rsp_r", rsp_r, e.r);
          check("rsp_id", 64'(rsp_id), 64'(e.id));
          last_rsp_r = rsp_r;
        end
      end
    end
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    sb.delete();
    model_last = N - 1;
    step();
    step();
    aresetn = 1'b1;
    step();
  endtask

  task automatic wait_hs(input int target);
    int n;
    n = 0;
    while (hs_count < target && n < 400) begin
      step();
      n++;
    end
    if (hs_count < target) check("hs_timeout", 64'(hs_count), 64'(target));
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  task automatic do_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    int t;
    t = hs_count + 1;
    set_op(i, a, b);
    req_valid = N'(1) << i;
    wait_hs(t);
    req_valid = '0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    rsp_ready = 1'b1;
    while ((sb.size() != 0 || busy) && n < 100) begin
      step();
      n++;
    end
    if (sb.size() != 0 || busy) check("done_timeout", 64'(sb.size()), 64'(0));
  endtask

  initial begin
    logic [63:0] cap_r;
    logic [1:0]  cap_id;
    int          base;
    int          rc;
    int          exp_order[5];
    int          n;

    // Reset values, with requests already asserted.
    req_valid = '1;
    #3;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_rsp_r", rsp_r, 64'(0));
    check("rst_rsp_id", 64'(rsp_id), 64'(0));
    check("rst_req_ready", 64'(req_ready), 64'(0));
    req_valid = '0;
    do_reset();

    // Idle with no requests.
    step();
    check("idle_req_ready", 64'(req_ready), 64'(0));
    check("idle_busy", 64'(busy), 64'(0));

    // Single request from requester 0.
    do_req(0, 32'd3, 32'd5);
    wait_done();
    check("first_prod", last_rsp_r, 64'd15);

    // All requesters held: grant order.
    do_reset();
    for (int i = 0; i < N; i++) set_op(i, W'(i + 2), W'(10 * i + 1));
    grants.delete();
    base = hs_count;
    req_valid = '1;
    wait_hs(base + 5);
    req_valid = '0;
    wait_done();
`ifdef MULT_ARBITER_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 3, 0};
`endif
    for (int i = 0; i < 5; i++)
      check("order", 64'(grants.size() > i ? grants[i] : -1), 64'(exp_order[i]));

    // Boundary operands.
    do_req(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done();
    check("max_prod", last_rsp_r, 64'hFFFF_FFFE_0000_0001);
    do_req(3, 32'h0, 32'h1234);
    wait_done();
    check("zero_prod", last_rsp_r, 64'h0);

    // Back-pressure in RESP.
    rsp_ready = 1'b0;
    do_req(1, 32'd11, 32'd13);
    n = 0;
    while (!rsp_valid && n < 60) begin
      step();
      n++;
    end
    check("bp_valid", 64'(rsp_valid), 64'(1));
    cap_r  = rsp_r;
    cap_id = rsp_id;
    check("bp_r", cap_r, 64'd143);
    check("bp_id", 64'(cap_id), 64'(1));
    req_valid = '1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_hold_valid", 64'(rsp_valid), 64'(1));
      check("bp_hold_r", rsp_r, cap_r);
      check("bp_hold_id", 64'(rsp_id), 64'(cap_id));
      check("bp_req_ready", 64'(req_ready), 64'(0));
      check("bp_busy", 64'(busy), 64'(1));
    end
    req_valid = '0;
    wait_done();

    // Reset in the middle of CALC.
    do_req(0, 32'd100, 32'd200);
    for (int i = 0; i < 9; i++) step();
    req_valid = '1;
    aresetn = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("mid_rst_rsp_r", rsp_r, 64'(0));
    check("mid_rst_rsp_id", 64'(rsp_id), 64'(0));
    check("mid_rst_req_ready", 64'(req_ready), 64'(0));
    sb.delete();
    model_last = N - 1;
    req_valid = '0;
    step();
    step();
    aresetn = 1'b1;
    rc = rise_cnt;
    for (int i = 0; i < 50; i++) step();
    check("no_rsp_after_rst", 64'(rise_cnt), 64'(rc));
    grants.delete();
    set_op(0, 32'd4, 32'd6);
    set_op(2, 32'd8, 32'd9);
    base = hs_count;
    req_valid = 4'b0101;
    wait_hs(base + 1);
    req_valid = '0;
    check("post_rst_grant", 64'(grants.size() > 0 ? grants[0] : -1), 64'(0));
    wait_done();

    // Operands change during CALC.
    do_req(1, 32'd7, 32'd9);
    set_op(1, 32'd1000, 32'd5);
    step();
    set_op(1, 32'hDEAD, 32'hBEEF);
    wait_done();
    check("isolation", last_rsp_r, 64'd63);

    // Random masks and operands.
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < N; i++) set_op(i, W'($urandom), W'($urandom));
      base = hs_count;
      req_valid = N'($urandom_range(1, 15));
      wait_hs(base + 1);
      req_valid = '0;
      wait_done();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
